mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: LINE_W, default 256, cacheline data width in bits; ADDR_W, default 32, address width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  instruction-side line read request
- i_addr  in  ADDR_W  instruction-side line address
- i_rdata  out  LINE_W  instruction-side read data
- i_resp  out  1  instruction-side completion pulse
- d_read  in  1  data-side line read request
- d_write  in  1  data-side line write request
- d_addr  in  ADDR_W  data-side line address
- d_wdata  in  LINE_W  data-side write data
- d_rdata  out  LINE_W  data-side read data
- d_resp  out  1  data-side completion pulse
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  LINE_W  downstream write data
- mem_rdata  in  LINE_W  downstream read data
- mem_resp  in  1  downstream completion
- arb_busy  out  1  high whenever state is not IDLE; feeds pipeline stall logic

Function
REQ-003 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-004 IDLE: if the D side is pending (d_read|d_write) and (I side idle or last_served==I), SHALL go to SERVE_D; else if i_read, SHALL go to SERVE_I; else SHALL stay in IDLE.
REQ-005 SHALL keep a 1-bit last_served register, updated on each grant; with both sides continuously pending, grants SHALL alternate D, I, D, I.
REQ-006 On grant, SHALL latch the address, the operation and (for D writes) the write data into internal registers; downstream outputs SHALL come only from the latched values and state.
REQ-007 mem_read/mem_write SHALL be high only in SERVE_I/SERVE_D and SHALL be held until mem_resp; in SERVE_I, mem_write SHALL be 0.
REQ-008 Latency: a request sampled in IDLE at cycle N SHALL produce a downstream strobe in cycle N+1.
REQ-009 mem_resp in SERVE_x at cycle M SHALL pulse the matching x_resp for exactly cycle M, pass mem_rdata to x_rdata in cycle M, and return to IDLE at M+1.
REQ-010 Minimum turnaround: the next grant's strobe SHALL appear no earlier than M+2.
REQ-011 i_resp and d_resp SHALL never be high in the same cycle; x_resp SHALL be 0 outside SERVE_x.
REQ-012 i_rdata and d_rdata SHALL be driven 0 when the matching resp is low.
REQ-013 d_read and d_write both high SHALL be treated as a write.
REQ-014 A requester dropping its request mid-transaction SHALL NOT abort it; the transaction SHALL complete and the resp SHALL still pulse.
REQ-015 mem_resp seen in IDLE SHALL be ignored, with no resp pulse and no state change.
REQ-016 Requester input changes after grant SHALL NOT alter mem_addr or mem_wdata.

Reset
REQ-017 rst high SHALL immediately, without waiting for clk, force state IDLE, last_served=I, and zero all latched registers and all outputs (strobes, resps, rdata, mem_addr, mem_wdata, arb_busy).
REQ-018 Reset mid-transaction SHALL drop the downstream strobe asynchronously; the in-flight transaction SHALL NOT be resumed after reset releases.

Verification
REQ-019 Single I read: i_read=1, i_addr=0x0000_0040 at cycle N -> mem_read=1, mem_addr=0x40 at N+1; mem_resp at N+3 with rdata=0xA5.. -> i_resp=1, i_rdata=0xA5.. at N+3, arb_busy=0 at N+4.
REQ-020 Simultaneous requests: i_read and d_write (addr 0x80) at N, last_served=I -> SERVE_D first, mem_write=1, mem_addr=0x80; after d_resp, I is granted with mem_read at the resp cycle +2.
REQ-021 Continuous contention over 6 grants -> grant order D,I,D,I,D,I; no cycle has both resps high.
REQ-022 Address change after grant: d_addr 0x100 granted, then d_addr changed to 0x200 while waiting -> mem_addr stays 0x100 until mem_resp.
REQ-023 Async reset mid-SERVE_I, asserted between clock edges -> mem_read=0 before the next edge; after release with no requests -> state IDLE, and a stray mem_resp produces no i_resp or d_resp.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port cacheline arbiter. An instruction port (read only) and a data port
// (read/write) share one downstream memory port. When both sides are pending,
// grants alternate between them. Each grant latches its request, so the
// downstream port sees stable values until mem_resp arrives.
module mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              arb_busy
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    // Request captured at grant time; the downstream port is driven only from this.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;   // 1: D side got the most recent grant
    req_t   req_q, req_d;
    logic   d_pend;

    assign d_pend = d_read | d_write;

    // Next-state, round-robin grant and request capture
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        req_d    = req_q;
        case (state_q)
            IDLE: begin
                if (d_pend && (!i_read || !last_d_q)) begin
                    state_d     = SERVE_D;
                    last_d_d    = 1'b1;
                    // read+write together counts as a write
                    req_d.write = d_write;
                    req_d.addr  = d_addr;
                    req_d.wdata = d_write ? d_wdata : '0;
                end else if (i_read) begin
                    state_d     = SERVE_I;
                    last_d_d    = 1'b0;
                    req_d.write = 1'b0;
                    req_d.addr  = i_addr;
                    req_d.wdata = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                // Completion only; requester inputs are ignored until back in IDLE
                if (mem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, fairness bit and latched request; async reset abandons any transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            req_q    <= req_d;
        end
    end

    // Downstream strobes and data come only from flops, so reset clears them at once
    always_comb begin
        arb_busy  = (state_q != IDLE);
        mem_read  = arb_busy && !req_q.write;
        mem_write = (state_q == SERVE_D) && req_q.write;
        mem_addr  = arb_busy ? req_q.addr  : '0;
        mem_wdata = arb_busy ? req_q.wdata : '0;
    end

    // Completion pulses go to the side being served; read data is zero outside the pulse
    always_comb begin
        i_resp  = (state_q == SERVE_I) && mem_resp;
        d_resp  = (state_q == SERVE_D) && mem_resp;
        i_rdata = i_resp ? mem_rdata : '0;
        d_rdata = d_resp ? mem_rdata : '0;
    end

endmodule
